mul16_seq: RTL and testbench
============================

# mul16_seq

Sequential 16×16 unsigned shift-and-add multiplier producing a 32-bit product. It feeds operands to one instance of the team's 16-bit carry-lookahead adder, CLA16, every iteration and consumes its sum. It is the multi-cycle MUL execution unit next to the ALU adder path. It uses a start/busy/done handshake and accepts one operation at a time.

## Interface
- No parameters; width is fixed at 16 (constants in package).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  16  multiplicand, captured on accepted start
- b  in  16  multiplier, captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when product is updated
- product  out  32  registered result, held until the next completion

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on a rising edge with start=1.
  - RUN→DONE when the iteration count reaches 16, or on the early exit (see Configuration).
  - DONE→IDLE unconditionally.
- Start accept edge: mcand←a; acc[31:0]←{16'h0000, b}; mplier←b; cnt←0.
- RUN, per edge:
  - Add condition: if acc[0]=1, CLA16 adds acc[31:16]+mcand with c_in=0. Carry-out is Gm (c_in=0), so cout=Gm. acc←{cout, sum, acc[15:1]}.
  - Otherwise acc←{1'b0, acc[31:1]}.
  - Always mplier←mplier>>1 and cnt←cnt+1.
- The edge that leaves RUN writes product←final acc value and enters DONE.
- Arithmetic is unsigned modulo nothing: the 32-bit result is exact (max 0xFFFE0001). The 17-bit {cout, sum} never overflows.
- start is ignored in RUN and DONE. Operand changes after acceptance have no effect.
- product changes only on RUN→DONE (or reset).

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0, acc/mcand/mplier/cnt=0. Reset mid-RUN aborts immediately; no partial product is written.
- Cycle numbering: start is sampled at edge E0.
  - busy=1 from after E0 through E16.
  - Edge E16 writes product and sets done=1 for exactly one cycle (E16→E17).
  - State is IDLE again after E17, and start is accepted at E18 at the earliest.
- Latency is 16 cycles from accept to done (macro off). Issue interval is 18 cycles.
- busy and done are never high simultaneously.
- Adder path is single-cycle combinational: acc[31:16]+mcand must settle within one clk period.

## Configuration
- MUL16_EARLY_EXIT_EN defined:
  - In RUN, if (mplier>>1)==0 on an edge, that edge is the exit edge.
  - product←(next acc)>>(15−cnt), where cnt is the pre-edge value.
  - RUN length = msb_index(b)+1 cycles; b=0 takes 1 cycle.
  - done follows on the next cycle as usual. Result is identical to the full run.
- MUL16_EARLY_EXIT_EN undefined:
  - Always exactly 16 RUN cycles; no shifter logic or mplier-zero detect is synthesized.
  - mplier may be omitted.

## Structure
- Shared package/include holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - MUL_W=16 and MUL_ITER=16;
  - counter width of 5 bits.
- One sub-module: a single CLA16 instance (a=acc[31:16], b=mcand, c_in=1'b0, sum, Gm as carry-out, Pm unused). No other hierarchy.

## Test plan
- Reset: assert rst asynchronously mid-cycle → busy=0, done=0, product=0 immediately; state IDLE after release.
- a=0x0003, b=0x0005, start at E0 → busy through E16, done pulse after E16, product=0x0000000F.
- a=0xFFFF, b=0xFFFF → product=0xFFFE0001 (exercises cout=Gm every iteration); a=0x8000, b=0x0002 → 0x00010000.
- Start held high through RUN with new operands a=7, b=9 during busy → first result unchanged; second op accepted only after return to IDLE, giving 0x3F.
- rst pulsed at RUN cycle 8 of a=0x1234, b=0x5678 → product stays 0, no done; a fresh start then yields 0x06260060.
- MUL16_EARLY_EXIT_EN defined:
  - a=0x1234, b=0x0001 → 1 RUN cycle, product=0x00001234;
  - b=0x0000 → 1 RUN cycle, product=0;
  - b=0x0100, a=0x00FF → 9 RUN cycles, product=0x0000FF00.

Source files
------------

// File: rtl/mul16_seq_pkg.sv
// mul16_seq_pkg
// Shared constants and state encoding for the sequential 16x16 multiplier.
// Optional feature macro used by the design: MUL16_EARLY_EXIT_EN.
//   MUL_W     operand width
//   MUL_ITER  number of shift-and-add iterations for a full run
//   CNT_W     width of the iteration counter (holds 0..16)
//   LAST_CNT  counter value on the final iteration edge of a full run
package mul16_seq_pkg;

  localparam int MUL_W    = 16;
  localparam int MUL_ITER = 16;
  localparam int CNT_W    = 5;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITER - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/mul16_seq_cla16.sv
// mul16_seq_cla16
// The team's 16-bit carry-lookahead adder (CLA16): four 4-bit lookahead
// groups joined by a second lookahead level.
// Ports:
//   a, b  in  16  addends
//   c_in  in  1   carry in
//   sum   out 16  a + b + c_in (low 16 bits)
//   gm    out 1   block generate (equals carry-out when c_in = 0)
//   pm    out 1   block propagate
module mul16_seq_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        gm,
  output logic        pm
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_c;

  // Bit generate/propagate, group generate/propagate, then the second
  // lookahead level produces each group's carry-in; carries inside a group
  // are expanded from that group carry so no ripple path exists.
  always_comb begin
    g = a & b;
    p = a ^ b;

    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end

    grp_c[0] = c_in;
    grp_c[1] = grp_g[0] | (grp_p[0] & c_in);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c_in);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & c_in);

    gm = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
       | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    pm = &grp_p;

    for (int k = 0; k < 4; k++) begin
      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end

    sum = p ^ c;
  end

endmodule

// File: rtl/mul16_seq.sv
// mul16_seq
// Sequential 16x16 unsigned shift-and-add multiplier (32-bit product) using
// one CLA16 adder per iteration. start/busy/done handshake, one op at a time.
// Optional feature: define MUL16_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (result re-aligned on exit).
// Ports:
//   clk      in  1   clock, rising edge
//   rst      in  1   asynchronous active-high reset
//   start    in  1   request, sampled only in IDLE
//   a        in  16  multiplicand, captured on accepted start
//   b        in  16  multiplier, captured on accepted start
//   busy     out 1   high while in RUN
//   done     out 1   one-cycle pulse when product is updated
//   product  out 32  registered result, held until next completion
module mul16_seq
  import mul16_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MUL_W-1:0]     a,
  input  logic [MUL_W-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*MUL_W-1:0]   product
);

  state_t               state;
  state_t               state_next;
  logic [2*MUL_W-1:0]   acc;
  logic [2*MUL_W-1:0]   acc_next;
  logic [2*MUL_W-1:0]   final_acc;
  logic [MUL_W-1:0]     mcand;
  logic [MUL_W-1:0]     cla_sum;
  logic                 cla_gm;
  logic                 cla_pm_unused;
  logic [CNT_W-1:0]     cnt;
  logic                 run_exit;

  // Upper half of the accumulator plus multiplicand; with c_in tied low the
  // block generate is the carry-out that becomes acc bit 31.
  mul16_seq_cla16 u_cla16 (
    .a    (acc[2*MUL_W-1:MUL_W]),
    .b    (mcand),
    .c_in (1'b0),
    .sum  (cla_sum),
    .gm   (cla_gm),
    .pm   (cla_pm_unused)
  );

  // One shift-and-add step: add the multiplicand into the upper half when the
  // current multiplier bit (acc[0]) is set, then shift everything right.
  always_comb begin
    if (acc[0]) begin
      acc_next = {cla_gm, cla_sum, acc[MUL_W-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*MUL_W-1:1]};
    end
  end

`ifdef MUL16_EARLY_EXIT_EN
  logic [MUL_W-1:0] mplier;

  // Exit once no set multiplier bits remain beyond the one consumed now; the
  // accumulator then still needs (15 - cnt) right shifts to be aligned.
  assign run_exit  = (mplier[MUL_W-1:1] == '0) || (cnt == LAST_CNT);
  assign final_acc = acc_next >> (LAST_CNT - cnt);

  // Remaining multiplier bits, used only for the early-exit detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mplier <= '0;
    end else if (state == IDLE && start) begin
      mplier <= b;
    end else if (state == RUN) begin
      mplier <= mplier >> 1;
    end
  end
`else
  assign run_exit  = (cnt == LAST_CNT);
  assign final_acc = acc_next;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; busy and done decode distinct states
  // so they can never be high together.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (run_exit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in RUN, and write the
  // product only on the edge that leaves RUN. Reset aborts with no write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{MUL_W{1'b0}}, b};
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (run_exit) product <= final_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq
// Self-checking bench for mul16_seq: directed cases from the design's corner
// cases plus randomized operands, compared to plain a*b and to the expected
// RUN length (16, or msb_index(b)+1 when MUL16_EARLY_EXIT_EN is defined).
module tb_mul16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int err_count   = 0;
  int check_count = 0;

  mul16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected number of cycles busy stays high for multiplier b.
  function automatic int expRun(input logic [15:0] bv);
    int msb_run;
    msb_run = 1;
    for (int i = 0; i < 16; i++) begin
      if (bv[i]) msb_run = i + 1;
    end
`ifdef MUL16_EARLY_EXIT_EN
    return msb_run;
`else
    return (msb_run > 0) ? 16 : 16;
`endif
  endfunction

  // busy and done must never overlap outside reset.
  always @(negedge clk) begin
    if (!rst) checkOutput("busy_done_excl", 32'(busy & done), 32'd0);
  end

  // Follows an op accepted on the coming edge through to completion.
  task automatic collect(input logic [15:0] op_a, input logic [15:0] op_b,
                         input bit keep_start, input logic [15:0] next_a,
                         input logic [15:0] next_b);
    int          n;
    logic [31:0] exp_p;
    exp_p = {16'h0, op_a} * {16'h0, op_b};
    @(negedge clk);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    if (keep_start) begin
      a_in = next_a;
      b_in = next_b;
    end else begin
      start = 1'b0;
      a_in  = 16'($urandom);
      b_in  = 16'($urandom);
    end
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput("run_cycles", 32'(n), 32'(expRun(op_b)));
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("product", product, exp_p);
    @(negedge clk);
    checkOutput("done_single", 32'(done), 32'd0);
    checkOutput("idle_after_done", 32'(busy), 32'd0);
    checkOutput("product_held", product, exp_p);
  endtask

  // Issue one multiplication and check its full handshake and result.
  task automatic applyStimulus(input logic [15:0] op_a, input logic [15:0] op_b);
    @(negedge clk);
    start = 1'b1;
    a_in  = op_a;
    b_in  = op_b;
    collect(op_a, op_b, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    bit          saw_done;
    logic [15:0] ra;
    logic [15:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed operands");
    applyStimulus(16'h0003, 16'h0005);
    applyStimulus(16'hFFFF, 16'hFFFF);
    applyStimulus(16'h8000, 16'h0002);
    applyStimulus(16'h1234, 16'h0001);
    applyStimulus(16'h1234, 16'h0000);
    applyStimulus(16'h00FF, 16'h0100);
    applyStimulus(16'h0000, 16'hFFFF);
    applyStimulus(16'hFFFF, 16'h8000);

    $display("[TB] start held through RUN with new operands");
    @(negedge clk);
    start = 1'b1;
    a_in  = 16'h0011;
    b_in  = 16'h0022;
    collect(16'h0011, 16'h0022, 1'b1, 16'd7, 16'd9);
    collect(16'd7, 16'd9, 1'b0, 16'h0, 16'h0);

    $display("[TB] reset abort mid-run");
    @(negedge clk);
    start = 1'b1;
    a_in  = 16'h1234;
    b_in  = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checkOutput("abort_no_done", 32'(saw_done), 32'd0);
    checkOutput("abort_product_zero", product, 32'd0);
    applyStimulus(16'h1234, 16'h5678);

    $display("[TB] randomized operands");
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      applyStimulus(ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
